// File: rtl/rv32_mod_mem_arbiter.sv
// rtl/rv32_mod_mem_arbiter.sv - fetch/data arbiter for the core's single memory/IO bus
//
// Purpose: grants one of two requesters (I = instruction fetch, D = load/store)
// onto a registered single-outstanding bus. Contention is resolved data-first
// with round-robin fairness.
//
// Optional watchdog: define RV32_MEM_ARB_TIMEOUT_EN to fail a transaction with
// an error ack after TIMEOUT_CYCLES cycles without bus_ack.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   i_req/i_addr                   fetch request (read only)
//   i_ack/i_rdata/i_err            fetch completion pulse, data, error
//   d_req/d_we/d_addr/d_wdata/d_be data request
//   d_ack/d_rdata/d_err            data completion pulse, data, error
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be   registered bus request fields
//   bus_ack/bus_rdata/bus_err      slave completion pulse, read data, error

module rv32_mod_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rstn,

  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,

  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // 1 = D was granted last, 0 = I was granted last (reset value).
  logic last_grant_d;
  logic grant_i;
  logic grant_d;
  logic busy;
  logic timeout_hit;
  logic done;

  assign busy = (state == BUSY_I) || (state == BUSY_D);
  assign done = busy && (bus_ack || timeout_hit);

`ifdef RV32_MEM_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  logic [WD_W-1:0] wd_cnt;

  // A bus_ack in the same cycle as the limit wins: normal completion.
  assign timeout_hit = busy && !bus_ack && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt <= '0;
    end else if (grant_i || grant_d) begin
      wd_cnt <= '0;
    end else if (busy && !bus_ack && !timeout_hit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // Watchdog compiled out; the parameter is referenced only so both builds
  // share one parameter list without an unused-parameter warning.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and grant decision. Grants are only evaluated in IDLE; on
  // contention the port that did not win last time is chosen.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || !last_grant_d)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus_ack || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus request registers and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_d <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= '0;
    end else if (grant_d) begin
      last_grant_d <= 1'b1;
      bus_req      <= 1'b1;
      bus_we       <= d_we;
      bus_addr     <= d_addr;
      bus_wdata    <= d_wdata;
      bus_be       <= d_be;
    end else if (grant_i) begin
      last_grant_d <= 1'b0;
      bus_req      <= 1'b1;
      bus_we       <= 1'b0;
      bus_addr     <= i_addr;
      bus_wdata    <= '0;
      bus_be       <= {BE_W{1'b1}};
    end else if (done) begin
      bus_req      <= 1'b0;
    end
  end

  // Completion is forwarded combinationally to the granted port only; read
  // data is zero whenever the port is not being acked or on a timeout.
  always_comb begin
    i_ack   = 1'b0;
    i_rdata = '0;
    i_err   = 1'b0;
    d_ack   = 1'b0;
    d_rdata = '0;
    d_err   = 1'b0;
    if (state == BUSY_I) begin
      i_ack = bus_ack || timeout_hit;
      if (bus_ack) begin
        i_rdata = bus_rdata;
        i_err   = bus_err;
      end else begin
        i_err   = timeout_hit;
      end
    end else if (state == BUSY_D) begin
      d_ack = bus_ack || timeout_hit;
      if (bus_ack) begin
        d_rdata = bus_rdata;
        d_err   = bus_err;
      end else begin
        d_err   = timeout_hit;
      end
    end
  end

endmodule

// File: doc/rv32_mod_mem_arbiter.md
Name: rv32_mod_mem_arbiter

Overview:
- Shares the core's single memory/IO bus between two requesters: the instruction fetch port (I) and the load/store data port (D).
- The D port serves instructions the decoder flags as mem_or_io.
- One transaction is in flight at a time; request fields are registered before they reach the bus.
- Contention is resolved data-first with round-robin fairness, so fetch cannot be starved.

Parameters:
- ADDR_W, 32, address width of both ports and the bus.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_ack.
- i_addr  in  ADDR_W  fetch address (read only).
- i_ack  out  1  1-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  DATA_W  fetched word; valid only while i_ack=1.
- i_err  out  1  bus error for fetch; qualified by i_ack.
- d_req  in  1  data request; held high with all fields stable until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables.
- d_ack  out  1  1-cycle pulse: data transaction complete.
- d_rdata  out  DATA_W  load data; valid only while d_ack=1.
- d_err  out  1  bus error for data; qualified by d_ack.
- bus_req  out  1  registered bus request.
- bus_we  out  1  registered write enable.
- bus_addr  out  ADDR_W  registered address.
- bus_wdata  out  DATA_W  registered write data.
- bus_be  out  DATA_W/8  registered byte enables.
- bus_ack  in  1  1-cycle completion pulse from the slave.
- bus_rdata  in  DATA_W  slave read data, valid with bus_ack.
- bus_err  in  1  slave error, valid with bus_ack.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; bus_req, bus_we, bus_addr, bus_wdata and bus_be all 0; last_grant=I; watchdog counter=0. i_ack and d_ack are 0 during reset.
- States:
  - IDLE: no transaction in flight.
  - BUSY_I: fetch transaction in flight.
  - BUSY_D: data transaction in flight.
- Grant rule, evaluated in IDLE only:
  - d_req only -> D.
  - i_req only -> I.
  - Both -> the port not equal to last_grant (round-robin). Since last_grant resets to I, the first contention goes to D.
- Grant edge: on the granting clock edge, latch the fields into the bus_* registers, set bus_req=1, update last_grant, and move to BUSY_x.
  - I grants drive bus_we=0 and bus_be all ones.
- Request-to-bus latency: a request sampled in IDLE at cycle N gives bus_req=1 at cycle N+1.
- BUSY_x, completion: when bus_ack=1, assert x_ack combinationally in the same cycle. x_rdata=bus_rdata and x_err=bus_err; the other port's ack stays 0. On that edge, clear bus_req and return to IDLE.
- Acks to the other port: never asserted while it is not granted, even if its req is high.
- Back-to-back: a requester may raise its next request in the cycle after its ack. Minimum turnaround is IDLE (1 cycle) + bus latency, so a 1-cycle slave gives one transaction every 2 cycles per stream.
- bus_ack while in IDLE is ignored and never forwarded.
- A requester deasserting req while BUSY is a protocol violation. The transaction still completes and the ack is still pulsed.
- Reset asserted mid-transaction aborts it. bus_req drops immediately and no ack is issued; the slave shares rstn.
- Out-of-range data ports (i_rdata/d_rdata when not acked) drive 0.

Optional Feature:
- Macro: RV32_MEM_ARB_TIMEOUT_EN.
- Enabled: an 8..16-bit counter clears on every grant and increments every cycle in BUSY_x with bus_ack=0. When it reaches TIMEOUT_CYCLES:
  - pulse x_ack=1 with x_err=1 and x_rdata=0;
  - clear bus_req and return to IDLE.
  - A bus_ack arriving in that same cycle takes precedence: normal completion.
- Disabled: no counter is present; the arbiter waits indefinitely for bus_ack.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, slave acks 2 cycles after bus_req with rdata=0x00000013 -> bus_addr=0x100, bus_we=0, bus_be=0xF one cycle after i_req; i_ack pulses once with i_rdata=0x13; d_ack stays 0.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=0x3, 1-cycle slave -> bus fields match; d_ack exactly 1 cycle; next grant no earlier than 2 cycles after the first grant.
- Contention: i_req and d_req held high continuously from reset, 1-cycle slave -> grant order D,I,D,I; each port acked 4 times in 16 cycles.
- Error: slave returns bus_ack=1, bus_err=1 on a load -> d_ack=1, d_err=1; i_err remains 0.
- Reset mid-flight: rstn=0 while BUSY_D -> bus_req=0 asynchronously, no d_ack. After release, a new i_req is granted normally and last_grant=I, so the next contention goes to D.
- Timeout (with RV32_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks -> i_ack=1, i_err=1 exactly 4 cycles after bus_req rises, then bus_req=0 and state returns to IDLE.
